// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_t;

  localparam int          ITERATIONS = 32;
  localparam logic [31:0] DIV0_LO    = 32'hFFFF_FFFF;

  // True for DIV and DIVU.
  function automatic logic op_is_div(input muldiv_op_t op);
    case (op)
      OP_DIV, OP_DIVU: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

  // True for the two's-complement variants (MULT and DIV).
  function automatic logic op_is_signed(input muldiv_op_t op);
    case (op)
      OP_MULT, OP_DIV: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

  // Conditionally negate a 32-bit value.
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
// Multiply: acc = {partial product, remaining multiplier bits}; radix-2 shift-add.
// Divide:   acc = {partial remainder, remaining dividend / quotient bits}; restoring.
module muldiv_step (
  input  logic        is_div,
  input  logic [63:0] acc_in,
  input  logic [31:0] operand,
  output logic [63:0] acc_out
);

  logic [32:0] sum_s;
  logic [31:0] trial_s;

  // Select the shift-add or restore step for this iteration.
  always_comb begin
    sum_s   = {1'b0, acc_in[63:32]} + {1'b0, operand};
    // Only used when the shifted remainder is >= divisor, so the true
    // difference is below 2^32 and the low 32 bits are exact.
    trial_s = acc_in[62:31] - operand;
    acc_out = acc_in;
    if (is_div) begin
      if (acc_in[63:31] >= {1'b0, operand}) begin
        acc_out = {trial_s, acc_in[30:0], 1'b1};
      end else begin
        acc_out = {acc_in[62:0], 1'b0};
      end
    end else begin
      if (acc_in[0]) begin
        acc_out = {sum_s, acc_in[31:1]};
      end else begin
        acc_out = {1'b0, acc_in[63:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv.sv
// muldiv: iterative MIPS multiply/divide unit with architectural HI/LO.
// Fixed 33-cycle latency: 32 RUN iterations plus one FIX cycle.
// Optional macro MULDIV_CHECK_EN compiles in simulation-only result checks.
module muldiv
  import muldiv_pkg::*;
(
  input  logic        Clock,
  input  logic        nReset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HiWrite,
  input  logic        LoWrite,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  muldiv_state_t state_r, state_nxt_s;
  muldiv_op_t    op_r, start_op_s;
  logic          sign_a_r, sign_b_r;
  logic          start_sign_a_s, start_sign_b_s;
  logic [31:0]   start_mag_a_s, start_mag_b_s;
  logic [5:0]    cnt_r;
  logic          last_iter_s;
  logic [31:0]   operand_r;
  logic [63:0]   acc_r, acc_step_s, product_s;
  logic          is_div_s;
  logic [31:0]   fix_hi_s, fix_lo_s;
  logic [31:0]   hi_r, lo_r;
  logic          busy_r, done_r;

  assign start_op_s  = muldiv_op_t'(Op);
  assign is_div_s    = op_is_div(op_r);
  assign last_iter_s = (cnt_r == 6'(ITERATIONS - 1));

  // Operand signs and magnitudes as seen at issue; unsigned ops pass raw values.
  always_comb begin
    start_sign_a_s = op_is_signed(start_op_s) & A[31];
    start_sign_b_s = op_is_signed(start_op_s) & B[31];
    start_mag_a_s  = neg_if(A, start_sign_a_s);
    start_mag_b_s  = neg_if(B, start_sign_b_s);
  end

  // FSM state register.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_iter_s) begin
          state_nxt_s = ST_FIX;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FIX:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  muldiv_step u_step (
    .is_div  (is_div_s),
    .acc_in  (acc_r),
    .operand (operand_r),
    .acc_out (acc_step_s)
  );

  // Operand capture at issue and one iteration per RUN cycle.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      op_r      <= OP_MULT;
      sign_a_r  <= 1'b0;
      sign_b_r  <= 1'b0;
      cnt_r     <= 6'd0;
      operand_r <= 32'd0;
      acc_r     <= 64'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (Start) begin
            op_r      <= start_op_s;
            sign_a_r  <= start_sign_a_s;
            sign_b_r  <= start_sign_b_s;
            cnt_r     <= 6'd0;
            // Divide iterates over the dividend with the divisor as operand;
            // multiply iterates over the multiplier with the multiplicand as operand.
            if (op_is_div(start_op_s)) begin
              acc_r     <= {32'd0, start_mag_a_s};
              operand_r <= start_mag_b_s;
            end else begin
              acc_r     <= {32'd0, start_mag_b_s};
              operand_r <= start_mag_a_s;
            end
          end
        end
        ST_RUN: begin
          acc_r <= acc_step_s;
          cnt_r <= cnt_r + 6'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Sign correction of the finished magnitude result.
  always_comb begin
    product_s = (sign_a_r ^ sign_b_r) ? (~acc_r + 64'd1) : acc_r;
    fix_hi_s  = product_s[63:32];
    fix_lo_s  = product_s[31:0];
    if (is_div_s) begin
      // With a zero divisor every trial subtraction succeeds, so the remainder
      // ends up holding |A| and re-applying A's sign restores the original A.
      fix_hi_s = neg_if(acc_r[63:32], sign_a_r);
      if (operand_r == 32'd0) begin
        fix_lo_s = DIV0_LO;
      end else begin
        fix_lo_s = neg_if(acc_r[31:0], sign_a_r ^ sign_b_r);
      end
    end else begin
      fix_lo_s = product_s[31:0];
    end
  end

  // HI/LO architectural registers and the Busy/Done status outputs.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      hi_r   <= 32'd0;
      lo_r   <= 32'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != ST_IDLE);
      done_r <= (state_r == ST_FIX);
      if (state_r == ST_FIX) begin
        hi_r <= fix_hi_s;
        lo_r <= fix_lo_s;
      end else if ((state_r == ST_IDLE) && !Start) begin
        if (HiWrite) begin
          hi_r <= A;
        end
        if (LoWrite) begin
          lo_r <= A;
        end
      end
    end
  end

  assign Busy = busy_r;
  assign Done = done_r;
  assign Hi   = hi_r;
  assign Lo   = lo_r;

`ifdef MULDIV_CHECK_EN
  logic [31:0]        chk_a_r, chk_b_r;
  logic signed [63:0] chk_sa_s, chk_sb_s;

  assign chk_sa_s = {{32{chk_a_r[31]}}, chk_a_r};
  assign chk_sb_s = {{32{chk_b_r[31]}}, chk_b_r};

  // Raw operands kept for comparison against plain arithmetic.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      chk_a_r <= 32'd0;
      chk_b_r <= 32'd0;
    end else if ((state_r == ST_IDLE) && Start) begin
      chk_a_r <= A;
      chk_b_r <= B;
    end
  end

  // Simulation-only result and protocol checks.
  always @(posedge Clock) begin
    if (nReset) begin
      if (state_r == ST_FIX) begin
        case (op_r)
          OP_MULT: assert ($signed({fix_hi_s, fix_lo_s}) == chk_sa_s * chk_sb_s)
                     else $error("muldiv: MULT result wrong");
          OP_MULTU: assert ({fix_hi_s, fix_lo_s} == ({32'd0, chk_a_r} * {32'd0, chk_b_r}))
                     else $error("muldiv: MULTU result wrong");
          OP_DIV: begin
            if ((chk_b_r != 32'd0) &&
                !((chk_a_r == 32'h8000_0000) && (chk_b_r == 32'hFFFF_FFFF))) begin
              assert ((fix_lo_s == 32'($signed(chk_a_r) / $signed(chk_b_r))) &&
                      (fix_hi_s == 32'($signed(chk_a_r) % $signed(chk_b_r))))
                else $error("muldiv: DIV result wrong");
            end
          end
          OP_DIVU: begin
            if (chk_b_r != 32'd0) begin
              assert ((fix_lo_s == chk_a_r / chk_b_r) && (fix_hi_s == chk_a_r % chk_b_r))
                else $error("muldiv: DIVU result wrong");
            end
          end
          default: begin
          end
        endcase
      end
      if (Start && (state_r != ST_IDLE)) begin
        $warning("muldiv: Start while busy ignored");
      end
      assert (!(done_r && busy_r)) else $error("muldiv: Done and Busy together");
    end
  end
`endif

endmodule

// File: doc/muldiv.md
# muldiv

Iterative MIPS multiply/divide unit with architectural HI/LO registers, fed by the register file's RsData/RtData read ports in the execute stage. Accepts MULT, MULTU, DIV and DIVU; each takes a fixed 33 cycles. Asserts Busy while an operation is in flight so the pipeline stalls MFHI/MFLO and further mul/div issues. Results are read back through Hi/Lo and written to the register file through its RdData path.

## Interface
- No parameters; data width fixed at 32.
- Clock  in  1  rising-edge clock
- nReset  in  1  asynchronous active-low reset
- Start  in  1  issue an operation; sampled only in IDLE
- Op  in  2  muldiv_op_t: MULT=0, MULTU=1, DIV=2, DIVU=3
- A  in  32  RsData; multiplicand or dividend
- B  in  32  RtData; multiplier or divisor
- HiWrite  in  1  MTHI: HI <= A; honoured only in IDLE with Start low
- LoWrite  in  1  MTLO: LO <= A; same rules as HiWrite
- Busy  out  1  operation in flight
- Done  out  1  single-cycle pulse; HI/LO hold the new result
- Hi  out  32  HI register
- Lo  out  32  LO register
- One clock; reset is asynchronous and active-low. The clock port is named Clock and the reset port nReset, matching the register file.

## Operation
- States: IDLE, RUN, FIX.
- IDLE with Start=1:
  - Latch Op and the sign flags of A and B.
  - Latch |A| and |B| for signed ops, raw A and B for unsigned ops.
  - Clear the 6-bit counter; go to RUN.
- RUN, one iteration per cycle, 32 iterations, then go to FIX:
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring divider, 32-bit remainder and quotient.
- FIX, one cycle, then go to IDLE:
  - Apply sign correction and write HI/LO.
  - MULT: negate the 64-bit product if the operand signs differ; HI = product[63:32], LO = product[31:0].
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend; HI = remainder, LO = quotient.
- Divide by zero (B=0, DIV or DIVU): HI = original A, LO = 32'hFFFF_FFFF, no sign correction applied.
- DIV of 32'h8000_0000 by 32'hFFFF_FFFF: LO = 32'h8000_0000, HI = 0. No trap.
- Start while Busy: ignored; the operation in flight is unaffected.
- HiWrite/LoWrite while Busy: ignored.
- Start together with HiWrite/LoWrite in IDLE: Start wins; the writes are dropped.
- Reset asserted mid-operation: aborts immediately. State = IDLE; HI, LO, counter and all internal registers = 0.

## Timing
- Reset values: Busy=0, Done=0, Hi=0, Lo=0.
- Start sampled at edge T0:
  - Busy high after T0 through the edge T33.
  - Edges T1..T32 perform iterations 1..32.
  - Edge T33: FIX writes HI/LO and sets Done.
  - Done is high for exactly one cycle (T33 to T34) while Busy=0.
- Latency from Start edge to valid Hi/Lo: 33 cycles. Back-to-back Start is accepted at T34.
- Hi and Lo are register outputs. They are stable throughout RUN and change only at FIX or on an accepted HiWrite/LoWrite.
- HiWrite/LoWrite take effect at the sampling edge and are visible the next cycle.

## Configuration
- MULDIV_CHECK_EN defined: compile in simulation-only immediate assertions.
  - At FIX, check {Hi,Lo} against the behavioural `*` result, or Hi/Lo against the behavioural `/` and `%` results when B≠0.
  - $warning on Start while Busy.
  - $error if Done and Busy are ever high together.
- MULDIV_CHECK_EN undefined: no checking logic; the RTL is identical otherwise.

## Structure
- muldiv_pkg holds:
  - muldiv_op_t enum and muldiv_state_t enum.
  - ITERATIONS = 32 constant.
  - DIV0_LO = 32'hFFFF_FFFF constant.
- One sub-module, muldiv_step: combinational single iteration, selecting a shift-add or restore step by Op.
- The top level holds the FSM, counter, operand/sign registers, sign fix and HI/LO.

## Test plan
- MULTU A=32'hFFFF_FFFF, B=32'hFFFF_FFFF -> Done 33 cycles after Start; Hi=32'hFFFF_FFFE, Lo=32'h0000_0001.
- MULT A=-7, B=3 -> Hi=32'hFFFF_FFFF, Lo=32'hFFFF_FFEB. DIV A=-7, B=2 -> Lo=32'hFFFF_FFFD (-3), Hi=32'hFFFF_FFFF (-1).
- DIVU A=100, B=0 -> Hi=100, Lo=32'hFFFF_FFFF. DIV A=32'h8000_0000, B=-1 -> Lo=32'h8000_0000, Hi=0.
- Start pulsed again at cycle 10 of a DIVU 50/7 -> ignored; Hi=1, Lo=7 at T33. Start at T34 is accepted.
- HiWrite A=32'hDEAD_BEEF during Busy -> no effect. The same write in IDLE -> Hi=32'hDEAD_BEEF next cycle. Start+LoWrite together -> Lo takes the operation result only.
- nReset low at cycle 15 of a MULT -> Busy=0, Hi=Lo=0 immediately, no Done. A new MULTU 3×5 after release -> Lo=15.
